mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequencer and arbiter for the single-ported, word-organised main memory of femtoRV32, shared between instruction fetch and the load/store path. Grants one requester at a time and drives the memory port. Performs byte-lane extraction and sign/zero extension for LB/LH/LW/LBU/LHU. Implements SB/SH as read-modify-write, since the memory has only whole-word writes. Sits between the core (fetch unit, EX/MEM stage) and the memory macro.

## Interface
- `MEM_AW`, default 8: memory word-address width. Depth is 2^MEM_AW words.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held until `if_ready`.
- `if_addr` in 32: fetch byte address; bits [1:0] are ignored.
- `if_ready` out 1: one-cycle pulse; `if_rdata` is valid in that cycle.
- `if_rdata` out 32: fetched word.
- `d_req` in 1: data request, held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_size` in 2: 00 word, 01 half, 10 byte, 11 illegal.
- `d_signed` in 1: 1 = sign-extend the load, 0 = zero-extend.
- `d_wdata` in 32: store data, right-aligned.
- `d_ready` out 1: one-cycle completion pulse.
- `d_err` out 1: valid with `d_ready`; indicates a misaligned or illegal access.
- `d_rdata` out 32: formatted load data, valid with `d_ready`.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out MEM_AW: memory word address.
- `mem_wdata` out 32: memory write word.
- `mem_rdata` in 32: memory read word, valid the cycle after an `mem_en`/!`mem_we` cycle.

## Operation
- Single FSM with states IDLE, IF_RD, D_RD, D_MERGE, D_RESP, D_ERRS.
- **Arbitration (IDLE only):**
  - If exactly one request is pending, grant it.
  - If both are pending, grant round-robin using the `last_grant` flag.
  - `last_grant` resets to "fetch", so data wins the first tie.
- **Latching:** on grant, the request fields (addr, size, signed, we, wdata) are captured in registers. Later states use only these registers.
- **Alignment check (data grant):**
  - Word with addr[1:0]≠0 → D_ERRS.
  - Half with addr[0]=1 → D_ERRS.
  - `d_size`=11 → D_ERRS.
  - D_ERRS performs no memory access.
- **Fetch grant:** IDLE issues the read, then → IF_RD. IF_RD drives `if_ready`=1 and `if_rdata`=`mem_rdata`, then → IDLE.
- **Load:** IDLE issues the read, then → D_RD. D_RD formats the data and drives `d_ready`=1, then → IDLE.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - The selected lane is extended to 32 bits per `d_signed`.
- **Word store:** IDLE issues the write (`mem_we`=1, `mem_wdata`=`d_wdata`), then → D_RESP. D_RESP drives `d_ready`=1, then → IDLE.
- **SB/SH store:** IDLE issues a read, then → D_MERGE.
  - D_MERGE writes back `mem_rdata` with the addressed lane replaced by `wdata[7:0]` (byte) or `wdata[15:0]` (half), then → D_RESP.
- **D_ERRS:** drives `d_ready`=1 and `d_err`=1, then → IDLE.
- **Idle outputs:** outside their ready cycle, `if_rdata` and `d_rdata` are 0, `d_err` is 0, and all `mem_*` strobes are 0.

## Timing
- Request sampled in IDLE at cycle N. Responses:
  - Fetch, load, word store, error: ready at N+1.
  - Sub-word store: write at N+1, `d_ready` at N+2.
- **Requester rule:** after sampling ready, the requester deasserts req or presents a new request. Because the FSM always returns to IDLE, there is at least 1 cycle between grants.
- **Ready timing:** ready pulses are exactly one cycle long and are combinational from state. `mem_*` outputs are combinational from state and latched fields.
- **Stalls:** the non-granted requester waits with its inputs held. No request is dropped.
- **Reset:** `rst` in any state → IDLE at the next edge, and `last_grant` returns to "fetch".
  - Outputs are forced 0 during the reset cycle.
  - A D_MERGE write coinciding with `rst` is suppressed (`mem_we`=0).
- **Mid-transaction requests:** a request arriving while busy is not seen until IDLE.

## Structure
- Shared package `mem_pkg` holds:
  - Size encodings: SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - The FSM state encoding.
- Sub-module `mem_lane_fmt` is combinational and contains:
  - Load lane select and extension.
  - Store lane merge.
- The FSM, arbiter and latches live in `mem_access_ctrl`.

## Test plan
- **Word load:** mem[3]=0x8000_00F0; load word @0x0C → `d_ready` at N+1, `d_rdata`=0x8000_00F0, `d_err`=0.
- **Byte loads:** mem[1]=0x1234_80FF.
  - LB @0x05 → 0xFFFF_FF80.
  - LBU @0x05 → 0x0000_0080.
  - LH @0x06 → 0x0000_1234.
- **SB:** mem[2]=0xAABB_CCDD; SB 0x11 @0x0A → read at N, write 0xAA11_CCDD at N+1, `d_ready` at N+2. Memory is unchanged in other lanes.
- **Contention:** `if_req` and `d_req` both asserted from reset → data granted first. On the next tie, fetch is granted. Neither requester is starved over 10 consecutive tie cycles.
- **Misaligned:** LW @0x02 and LH @0x03 → `d_ready`=`d_err`=1 at N+1, `mem_en` never asserted.
- **Reset mid-operation:** `rst` asserted in the D_MERGE cycle → no memory write. IDLE next cycle, all outputs 0, and a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the femtoRV32 memory access controller: access sizes,
// FSM states and the alignment rule used at grant time.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_RD   = 3'd1,
    D_RD    = 3'd2,
    D_MERGE = 3'd3,
    D_RESP  = 3'd4,
    D_ERRS  = 3'd5
  } mem_state_t;

  // True when a data access cannot be served by one aligned word access.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lsb);
    return (size == SZ_ILL) ||
           ((size == SZ_WORD) && (lsb != 2'b00)) ||
           ((size == SZ_HALF) && lsb[0]);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane logic: load lane select/extension and the
// sub-word store merge into a previously read memory word.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase

    o_ld_data = i_rdata;
    if (i_size == SZ_HALF)
      o_ld_data = {{16{i_signed & w_half[15]}}, w_half};
    else if (i_size == SZ_BYTE)
      o_ld_data = {{24{i_signed & w_byte[7]}}, w_byte};

    o_st_data = i_wdata;
    if (i_size == SZ_HALF) begin
      o_st_data = i_lane[1] ? {i_wdata[15:0], i_rdata[15:0]}
                            : {i_rdata[31:16], i_wdata[15:0]};
    end else if (i_size == SZ_BYTE) begin
      case (i_lane)
        2'd0:    o_st_data = {i_rdata[31:8], i_wdata[7:0]};
        2'd1:    o_st_data = {i_rdata[31:16], i_wdata[7:0], i_rdata[7:0]};
        2'd2:    o_st_data = {i_rdata[31:24], i_wdata[7:0], i_rdata[15:0]};
        default: o_st_data = {i_wdata[7:0], i_rdata[23:0]};
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbiter and sequencer for the single-ported word memory shared by
// instruction fetch and load/store; sub-word stores are read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output mem_state_t        dbg_state
);

  // Handshake: a requester holds req and its fields until it sees a one-cycle
  // ready pulse; requests are only sampled in IDLE, so busy-time requests wait.
  mem_state_t        r_state, w_next;
  logic              r_last_data;
  logic [MEM_AW+1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;

  logic        w_grant_d, w_grant_f, w_bad;
  logic [31:0] w_ld_data, w_st_data;
  logic        w_unused;

  assign w_unused  = ^{if_addr[31:MEM_AW+2], if_addr[1:0], d_addr[31:MEM_AW+2]};
  assign w_grant_d = d_req && (!if_req || !r_last_data);
  assign w_grant_f = if_req && !w_grant_d;
  assign w_bad     = access_bad(d_size, d_addr[1:0]);
  assign dbg_state = r_state;

  mem_lane_fmt u_fmt (
    .i_rdata  (mem_rdata),
    .i_wdata  (r_wdata),
    .i_size   (r_size),
    .i_lane   (r_addr[1:0]),
    .i_signed (r_signed),
    .o_ld_data(w_ld_data),
    .o_st_data(w_st_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_data <= 1'b0;
      r_addr      <= '0;
      r_size      <= SZ_WORD;
      r_signed    <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant_d) begin
        r_last_data <= 1'b1;
        r_addr      <= d_addr[MEM_AW+1:0];
        r_size      <= d_size;
        r_signed    <= d_signed;
        r_wdata     <= d_wdata;
      end else if (r_state == IDLE && w_grant_f) begin
        r_last_data <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          if (w_bad) begin
            w_next = D_ERRS;
          end else begin
            mem_en   = 1'b1;
            mem_addr = d_addr[MEM_AW+1:2];
            if (d_we && d_size == SZ_WORD) begin
              mem_we    = 1'b1;
              mem_wdata = d_wdata;
              w_next    = D_RESP;
            end else if (d_we) begin
              w_next = D_MERGE;
            end else begin
              w_next = D_RD;
            end
          end
        end else if (w_grant_f) begin
          mem_en   = 1'b1;
          mem_addr = if_addr[MEM_AW+1:2];
          w_next   = IF_RD;
        end
      end
      IF_RD: begin
        if_ready = 1'b1;
        if_rdata = mem_rdata;
        w_next   = IDLE;
      end
      D_RD: begin
        d_ready = 1'b1;
        d_rdata = w_ld_data;
        w_next  = IDLE;
      end
      D_MERGE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr[MEM_AW+1:2];
        mem_wdata = w_st_data;
        w_next    = D_RESP;
      end
      D_RESP: begin
        d_ready = 1'b1;
        w_next  = IDLE;
      end
      D_ERRS: begin
        d_ready = 1'b1;
        d_err   = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset blanks every output, which also suppresses an in-flight merge write.
    if (rst) begin
      if_ready  = 1'b0;
      if_rdata  = '0;
      d_ready   = 1'b0;
      d_err     = 1'b0;
      d_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule
